// File: rtl/sequence_sc_pkg.sv
// Shared definitions for the sequence generator and sequence detector.
//   SeqWidth    : default maximum pattern length in bits
//   SeqLw       : default width of the length/index fields (2**SeqLw > SeqWidth)
//   seq_state_e : two-state encoding used by both blocks
package sequence_sc_pkg;

  localparam int unsigned SeqWidth = 32;
  localparam int unsigned SeqLw    = 6;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } seq_state_e;

endpackage

// File: rtl/sequence_generator_sc.sv
// Serialises a latched bit pattern, MSB first, one bit per clock.
// The pattern can repeat without gaps, and a transmission can be aborted.
//   clk       : single clock, rising edge
//   reset     : asynchronous active-low reset
//   start     : begin a transmission (sampled only while idle)
//   abort     : synchronous stop of a transmission in progress
//   pattern   : bit pattern, latched on an accepted start
//   length    : number of bits to send (clamped to WIDTH), latched on an accepted start
//   repeat_en : restart the latched pattern after its last bit (sampled live)
//   out       : registered serial bit
//   busy      : high while sending
//   done      : one-cycle pulse after the last bit of a non-repeating pass
//   bit_idx   : index of the bit currently on out; 0 when idle
module sequence_generator_sc
  import sequence_sc_pkg::*;
#(
  parameter int unsigned WIDTH = SeqWidth,
  parameter int unsigned LW    = SeqLw
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    length,
  input  logic             repeat_en,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    bit_idx
);

  seq_state_e       state_q;
  logic [WIDTH-1:0] pat_q;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    idx_q;
  logic             out_q;
  logic             busy_q;
  logic             done_q;

  logic [LW-1:0]    len_clamp;
  logic             start_ok;
  logic [WIDTH-1:0] sel_pat;
  logic [LW-1:0]    sel_idx;
  logic [WIDTH-1:0] sel_shift;
  logic             next_bit;

  assign len_clamp = (length > LW'(WIDTH)) ? LW'(WIDTH) : length;
  assign start_ok  = start && !abort && (length != '0);

  // Select which bit is driven next: the live pattern's top bit on a start,
  // the latched MSB on a wrap, otherwise the next lower latched bit.
  always_comb begin
    sel_pat = pat_q;
    sel_idx = idx_q - LW'(1);
    if (state_q == StIdle) begin
      sel_pat = pattern;
      sel_idx = len_clamp - LW'(1);
    end else if (idx_q == '0) begin
      sel_idx = len_q - LW'(1);
    end
  end

  assign sel_shift = sel_pat >> sel_idx;
  assign next_bit  = sel_shift[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q <= StSend;
            pat_q   <= pattern;
            len_q   <= len_clamp;
            idx_q   <= sel_idx;
            out_q   <= next_bit;
            busy_q  <= 1'b1;
          end
        end
        StSend: begin
          if (abort) begin
            // Abort wins over end-of-pattern and repeat; no done pulse.
            state_q <= StIdle;
            idx_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if ((idx_q == '0) && !repeat_en) begin
            state_q <= StIdle;
            idx_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= sel_idx;
            out_q <= next_bit;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_sequence_generator_sc.sv
module tb_sequence_generator_sc;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LW    = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    length;
  logic             repeat_en;
  logic             out;
  logic             busy;
  logic             done;
  logic [LW-1:0]    bit_idx;

  int n_checks = 0;
  int n_errors = 0;

  sequence_generator_sc #(
    .WIDTH(WIDTH),
    .LW   (LW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .length   (length),
    .repeat_en(repeat_en),
    .out      (out),
    .busy     (busy),
    .done     (done),
    .bit_idx  (bit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out"}, 64'(out), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".bit_idx"}, 64'(bit_idx), 64'd0);
  endtask

  logic [31:0] exp32;
  logic [14:0] exp15;
  logic [7:0]  exp8;
  logic [3:0]  exp4;
  int          done_seen;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    pattern   = '0;
    length    = '0;
    repeat_en = 1'b0;
    #12;
    check_idle("reset");
    check("reset.done", 64'(done), 64'd0);
    reset = 1'b1;
    step();
    check_idle("post_reset");

    // 32-bit single pass.
    exp32   = 32'b00101011010111000101011001010110;
    pattern = 32'h2B5C5656;
    length  = 6'd32;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("p32.out[%0d]", i), 64'(out), 64'(exp32[31-i]));
      check($sformatf("p32.idx[%0d]", i), 64'(bit_idx), 64'(31 - i));
      check("p32.busy", 64'(busy), 64'd1);
      check("p32.done_low", 64'(done), 64'd0);
      step();
    end
    check("p32.done", 64'(done), 64'd1);
    check_idle("p32.end");
    step();
    check("p32.done_once", 64'(done), 64'd0);

    // Repeat three passes of 10110.
    exp15     = 15'b101101011010110;
    pattern   = 32'b10110;
    length    = 6'd5;
    repeat_en = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 12) repeat_en = 1'b0;
      check($sformatf("rep.out[%0d]", i), 64'(out), 64'(exp15[14-i]));
      check("rep.busy", 64'(busy), 64'd1);
      check("rep.done_low", 64'(done), 64'd0);
      step();
    end
    check("rep.done", 64'(done), 64'd1);
    check_idle("rep.end");
    step();
    check("rep.done_once", 64'(done), 64'd0);

    // Zero length is ignored.
    pattern = 32'hFFFF_FFFF;
    length  = 6'd0;
    start   = 1'b1;
    step();
    start = 1'b0;
    check_idle("len0");
    check("len0.done", 64'(done), 64'd0);
    step();
    check("len0.done2", 64'(done), 64'd0);

    // Start and input changes during SEND do not disturb the transmission.
    exp8    = 8'hA5;
    pattern = 32'hA5;
    length  = 6'd8;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        start   = 1'b1;
        pattern = 32'h0000_005A;
        length  = 6'd20;
      end
      if (i == 4) start = 1'b0;
      check($sformatf("midstart.out[%0d]", i), 64'(out), 64'(exp8[7-i]));
      check($sformatf("midstart.idx[%0d]", i), 64'(bit_idx), 64'(7 - i));
      step();
    end
    check("midstart.done", 64'(done), 64'd1);
    step();

    // Abort at bit_idx 3 of a 16-bit send.
    pattern = 32'hF0F0;
    length  = 6'd16;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("abort.at_idx3", 64'(bit_idx), 64'd3);
    check("abort.busy_before", 64'(busy), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("abort");
    check("abort.done", 64'(done), 64'd0);
    step();
    check("abort.done2", 64'(done), 64'd0);

    // Asynchronous reset mid-pass, then a fresh start.
    pattern = 32'hFF;
    length  = 6'd8;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    #3;
    reset = 1'b0;
    #1;
    check_idle("areset");
    check("areset.done", 64'(done), 64'd0);
    #2;
    reset = 1'b1;
    step();
    check_idle("areset.wait");
    check("areset.done2", 64'(done), 64'd0);
    exp4    = 4'b1001;
    pattern = 32'b1001;
    length  = 6'd4;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("areset.new[%0d]", i), 64'(out), 64'(exp4[3-i]));
      step();
    end
    check("areset.new_done", 64'(done), 64'd1);
    step();

    // Length clamp and start held through done.
    exp32   = 32'hC000_0003;
    pattern = 32'hC000_0003;
    length  = 6'd40;
    start   = 1'b1;
    step();
    check("clamp.idx", 64'(bit_idx), 64'd31);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("clamp.out[%0d]", i), 64'(out), 64'(exp32[31-i]));
      step();
    end
    check("clamp.done", 64'(done), 64'd1);
    check("clamp.busy_gap", 64'(busy), 64'd0);
    step();
    check("clamp.second_busy", 64'(busy), 64'd1);
    check("clamp.second_idx", 64'(bit_idx), 64'd31);
    check("clamp.second_out", 64'(out), 64'd1);
    check("clamp.second_done", 64'(done), 64'd0);
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("clamp.abort");

    done_seen = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sequence_generator_sc.md
SEQUENCE_GENERATOR_SC -- requirements
Module: sequence_generator_sc

Interface
REQ-001 SHALL have parameter: WIDTH, 32, maximum pattern length in bits.
REQ-002 SHALL have parameter: LW, 6, width of length/index fields; the value shall satisfy 2**LW > WIDTH.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 SHALL have port: abort  input  1  synchronous stop of any transmission in progress.
REQ-007 SHALL have port: pattern  input  WIDTH  bit pattern to serialise; latched on an accepted start.
REQ-008 SHALL have port: length  input  LW  number of bits to send; latched on an accepted start.
REQ-009 SHALL have port: repeat_en  input  1  restart the latched pattern after its last bit; sampled live.
REQ-010 SHALL have port: out  output  1  registered serial bit stream.
REQ-011 SHALL have port: busy  output  1  high while in SEND.
REQ-012 SHALL have port: done  output  1  one-cycle pulse after the final bit of a non-repeating pass.
REQ-013 SHALL have port: bit_idx  output  LW  index of the bit currently driven on out; 0 when idle.

Function
REQ-014 SHALL implement two states: IDLE and SEND.
REQ-015 SHALL accept a start on the edge at which state=IDLE, start=1, abort=0 and length!=0; any other start shall be ignored without a done pulse.
REQ-016 SHALL clamp a latched length greater than WIDTH to WIDTH.
REQ-017 SHALL, on the edge that accepts a start, enter SEND and drive out=pattern[L-1] and bit_idx=L-1, so the first bit is valid in the following cycle (latency 1).
REQ-018 SHALL transmit MSB-first, down to bit 0; each bit shall be held on out for exactly one clock.
REQ-019 SHALL, on the edge ending bit 0 with repeat_en=1, reload bit_idx=L-1 and drive the latched pattern's MSB, with no gap cycle and busy staying high.
REQ-020 SHALL, on the edge ending bit 0 with repeat_en=0, return to IDLE with out=0, busy=0, bit_idx=0 and done=1 for exactly one cycle.
REQ-021 SHALL ignore start while in SEND; changes on pattern or length during SEND shall not affect the transmission in progress.
REQ-022 SHALL, when abort=1 at an edge in SEND, return to IDLE with out=0 and no done pulse; abort shall take priority over end-of-pattern and repeat.
REQ-023 SHALL accept a start in the IDLE cycle in which done is high (back-to-back transmissions).

Reset
REQ-024 SHALL, while reset=0, asynchronously force state=IDLE, out=0, busy=0, done=0, bit_idx=0 and clear the latched pattern and length.
REQ-025 SHALL treat reset asserted mid-transmission as an abort with no done pulse; after release, the block shall wait for a new start.

Structure
REQ-026 SHALL take the state encoding (IDLE, SEND) and the WIDTH/LW defaults from a shared package, sequence_sc_pkg, so the generator and the team's sequence detector use common definitions.
REQ-027 SHALL be a single module with no sub-modules; the datapath is a latched pattern register plus a down-counting index.

Verification
REQ-028 SHALL cover: pattern=32'h2B5C5656, length=32, start pulse -> out=00101011010111000101011001010110 over 32 cycles beginning 1 cycle after start, then done=1 for 1 cycle.
REQ-029 SHALL cover: pattern=5'b10110, length=5, repeat_en=1 for 3 passes, then 0 -> 101101011010110, busy high for 15 cycles, a single done pulse at the end.
REQ-030 SHALL cover: length=0 with start, and start pulsed during SEND -> no state change and no done pulse; the transmission in progress is unaffected.
REQ-031 SHALL cover: abort at bit_idx=3 of a 16-bit send -> out=0 and busy=0 on the next cycle, done stays 0.
REQ-032 SHALL cover: reset low mid-pass, then high, then a new start -> outputs 0 immediately and asynchronously; the new pattern is sent from its MSB.
REQ-033 SHALL cover: length=40 with WIDTH=32 -> exactly 32 bits sent; start held high through done -> second pass begins the cycle after done.
